// File: rtl/cdb_pkg.sv
// cdb_pkg: source IDs, width defaults and result record shared by the CDB arbiter files.
package cdb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF = 5;
  localparam int PHY_W_DEF = 6;
  localparam logic [1:0] SRC_INT = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_MUL = 2'd2;
  localparam logic [1:0] SRC_DIV = 2'd3;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]  rob_tag;
    logic [PHY_W_DEF-1:0]  phy_addr;
  } cdb_res_t;
endpackage

// File: rtl/cdb_hold_slot.sv
// cdb_hold_slot: one-entry hold buffer, candidate select, flush kill and Ready for one CDB source.
module cdb_hold_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 5,
  parameter int PHY_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [PHY_W-1:0]  phy_i,
  input  logic [TAG_W-1:0]  top_ptr_i,
  input  logic              flush_i,
  input  logic [TAG_W-1:0]  flush_depth_i,
  input  logic              grant_i,
  output logic              cand_v_o,
  output logic [DATA_W-1:0] cand_data_o,
  output logic [TAG_W-1:0]  cand_tag_o,
  output logic [PHY_W-1:0]  cand_phy_o,
  output logic              ready_o
);
  logic              hold_v_q, hold_v_d;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  logic [PHY_W-1:0]  phy_q;
  logic [TAG_W-1:0]  depth;
  logic              live_v, kill;
  always_comb begin
    live_v      = valid_i & ~hold_v_q;
    cand_data_o = hold_v_q ? data_q : data_i;
    cand_tag_o  = hold_v_q ? tag_q : tag_i;
    cand_phy_o  = hold_v_q ? phy_q : phy_i;
    depth       = cand_tag_o - top_ptr_i;
    kill        = flush_i & (depth > flush_depth_i);
    cand_v_o    = (hold_v_q | live_v) & ~kill;
    hold_v_d    = cand_v_o & ~grant_i;
  end
  // payload only loads while empty, so a held entry is never overwritten
  always_ff @(posedge clk) begin
    hold_v_q <= rst ? 1'b0 : hold_v_d;
    if (!hold_v_q) begin
      data_q <= data_i;
      tag_q  <= tag_i;
      phy_q  <= phy_i;
    end
  end
  assign ready_o = ~hold_v_q | rst;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB among Int/Lsb/Mul/Div with per-source hold buffers and flush kill.
// Optional CDB_ARB_STATS_EN adds per-source saturating conflict counters on Stat_Conflict.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int PHY_W = PHY_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Int_Valid,
  input  logic [DATA_W-1:0] Int_Data,
  input  logic [TAG_W-1:0]  Int_RobTag,
  input  logic [PHY_W-1:0]  Int_PhyAddr,
  output logic              Int_Ready,
  input  logic              Lsb_Valid,
  input  logic [DATA_W-1:0] Lsb_Data,
  input  logic [TAG_W-1:0]  Lsb_RobTag,
  input  logic [PHY_W-1:0]  Lsb_PhyAddr,
  output logic              Lsb_Ready,
  input  logic              Mul_Valid,
  input  logic [DATA_W-1:0] Mul_Data,
  input  logic [TAG_W-1:0]  Mul_RobTag,
  input  logic [PHY_W-1:0]  Mul_PhyAddr,
  output logic              Mul_Ready,
  input  logic              Div_Valid,
  input  logic [DATA_W-1:0] Div_Data,
  input  logic [TAG_W-1:0]  Div_RobTag,
  input  logic [PHY_W-1:0]  Div_PhyAddr,
  output logic              Div_Ready,
  input  logic [TAG_W-1:0]  Rob_TopPtr,
  input  logic              Flush,
  input  logic [TAG_W-1:0]  Flush_RobDepth,
`ifdef CDB_ARB_STATS_EN
  output logic [63:0]       Stat_Conflict,
`endif
  output logic              Cdb_Valid,
  output logic [DATA_W-1:0] Cdb_Data,
  output logic [TAG_W-1:0]  Cdb_RobTag,
  output logic [PHY_W-1:0]  Cdb_PhyAddr,
  output logic [1:0]        Cdb_Src
);
  logic [3:0]        vld, cand_v, gnt, rdy;
  logic [DATA_W-1:0] din [4];
  logic [TAG_W-1:0]  tin [4];
  logic [PHY_W-1:0]  pin [4];
  logic [DATA_W-1:0] cdat [4];
  logic [TAG_W-1:0]  ctag [4];
  logic [PHY_W-1:0]  cphy [4];
  logic [1:0]        win;
  logic              any, both, rr_q, rr_d;
  logic              cdb_v_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [PHY_W-1:0]  cdb_phy_q;
  logic [1:0]        cdb_src_q;
  assign vld = {Div_Valid, Mul_Valid, Lsb_Valid, Int_Valid};
  assign din = '{Int_Data, Lsb_Data, Mul_Data, Div_Data};
  assign tin = '{Int_RobTag, Lsb_RobTag, Mul_RobTag, Div_RobTag};
  assign pin = '{Int_PhyAddr, Lsb_PhyAddr, Mul_PhyAddr, Div_PhyAddr};
  assign {Div_Ready, Mul_Ready, Lsb_Ready, Int_Ready} = rdy;
  for (genvar g = 0; g < 4; g++) begin : g_slot
    cdb_hold_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W), .PHY_W(PHY_W)) u_slot (
      .clk(Clk), .rst(Reset), .valid_i(vld[g]), .data_i(din[g]), .tag_i(tin[g]), .phy_i(pin[g]),
      .top_ptr_i(Rob_TopPtr), .flush_i(Flush), .flush_depth_i(Flush_RobDepth), .grant_i(gnt[g]),
      .cand_v_o(cand_v[g]), .cand_data_o(cdat[g]), .cand_tag_o(ctag[g]), .cand_phy_o(cphy[g]),
      .ready_o(rdy[g])
    );
  end
  // long-latency units drain first; Int/Lsb share a round-robin bit that moves only when they fight
  always_comb begin
    both = cand_v[SRC_INT] & cand_v[SRC_LSB];
    any  = |cand_v;
    win  = cand_v[SRC_DIV] ? SRC_DIV : cand_v[SRC_MUL] ? SRC_MUL :
           both ? (rr_q ? SRC_LSB : SRC_INT) : cand_v[SRC_INT] ? SRC_INT : SRC_LSB;
    gnt  = {3'b000, any} << win;
    rr_d = (both & ~cand_v[SRC_DIV] & ~cand_v[SRC_MUL]) ? ~rr_q : rr_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cdb_v_q    <= 1'b0;
      cdb_data_q <= '0;
      cdb_tag_q  <= '0;
      cdb_phy_q  <= '0;
      cdb_src_q  <= SRC_INT;
      rr_q       <= 1'b0;
    end else begin
      cdb_v_q <= any;
      rr_q    <= rr_d;
      if (any) begin
        cdb_data_q <= cdat[win];
        cdb_tag_q  <= ctag[win];
        cdb_phy_q  <= cphy[win];
        cdb_src_q  <= win;
      end
    end
  end
  assign Cdb_Valid   = cdb_v_q;
  assign Cdb_Data    = cdb_data_q;
  assign Cdb_RobTag  = cdb_tag_q;
  assign Cdb_PhyAddr = cdb_phy_q;
  assign Cdb_Src     = cdb_src_q;
`ifdef CDB_ARB_STATS_EN
  logic [15:0] stat_q [4];
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      if (Reset) stat_q[i] <= '0;
      else if (cand_v[i] & ~gnt[i] & ~&stat_q[i]) stat_q[i] <= stat_q[i] + 16'd1;
  end
  assign Stat_Conflict = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus randomized checks of cdb_arbiter against a queue-level reference model.
module tb_cdb_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  vld;
  logic [31:0] dat [4];
  logic [4:0]  tag [4];
  logic [5:0]  phy [4];
  logic [4:0]  top, fd;
  logic        fl;
  logic        r0, r1, r2, r3;
  logic [3:0]  rdy;
  logic        Cdb_Valid;
  logic [31:0] Cdb_Data;
  logic [4:0]  Cdb_RobTag;
  logic [5:0]  Cdb_PhyAddr;
  logic [1:0]  Cdb_Src;
  int checks = 0;
  int errors = 0;
  bit          h_v [4];
  logic [31:0] h_d [4];
  logic [4:0]  h_t [4];
  logic [5:0]  h_p [4];
  bit          m_v, m_rr;
  logic [31:0] m_d;
  logic [4:0]  m_t;
  logic [5:0]  m_p;
  logic [1:0]  m_s;
  assign rdy = {r3, r2, r1, r0};
  always #5 Clk = ~Clk;

  cdb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Int_Valid(vld[0]), .Int_Data(dat[0]), .Int_RobTag(tag[0]), .Int_PhyAddr(phy[0]), .Int_Ready(r0),
    .Lsb_Valid(vld[1]), .Lsb_Data(dat[1]), .Lsb_RobTag(tag[1]), .Lsb_PhyAddr(phy[1]), .Lsb_Ready(r1),
    .Mul_Valid(vld[2]), .Mul_Data(dat[2]), .Mul_RobTag(tag[2]), .Mul_PhyAddr(phy[2]), .Mul_Ready(r2),
    .Div_Valid(vld[3]), .Div_Data(dat[3]), .Div_RobTag(tag[3]), .Div_PhyAddr(phy[3]), .Div_Ready(r3),
    .Rob_TopPtr(top), .Flush(fl), .Flush_RobDepth(fd),
    .Cdb_Valid(Cdb_Valid), .Cdb_Data(Cdb_Data), .Cdb_RobTag(Cdb_RobTag),
    .Cdb_PhyAddr(Cdb_PhyAddr), .Cdb_Src(Cdb_Src)
  );

  // sources must never present a result while not Ready
  always @(posedge Clk)
    if (!Reset)
      for (int s = 0; s < 4; s++)
        assert (!(vld[s] && !rdy[s])) else $error("FAIL protocol src %0d valid while not ready", s);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: each source owns a one-deep queue; pick the winner by the arbitration rules
  task automatic cycle();
    bit alive [4];
    logic [31:0] cd [4];
    logic [4:0] ct [4];
    logic [5:0] cp [4];
    int win;
    logic [3:0] er;
    if (Reset) begin
      for (int s = 0; s < 4; s++) h_v[s] = 0;
      m_v = 0; m_d = 0; m_t = 0; m_p = 0; m_s = 0; m_rr = 0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        cd[s] = h_v[s] ? h_d[s] : dat[s];
        ct[s] = h_v[s] ? h_t[s] : tag[s];
        cp[s] = h_v[s] ? h_p[s] : phy[s];
        alive[s] = (h_v[s] || vld[s]) && !(fl && ((int'(ct[s]) + 32 - int'(top)) % 32) > int'(fd));
      end
      win = -1;
      if (alive[3]) win = 3;
      else if (alive[2]) win = 2;
      else if (alive[0] && alive[1]) begin win = m_rr ? 1 : 0; m_rr = !m_rr; end
      else if (alive[0]) win = 0;
      else if (alive[1]) win = 1;
      for (int s = 0; s < 4; s++) begin
        h_v[s] = alive[s] && s != win;
        h_d[s] = cd[s]; h_t[s] = ct[s]; h_p[s] = cp[s];
      end
      m_v = win >= 0;
      if (m_v) begin m_d = cd[win]; m_t = ct[win]; m_p = cp[win]; m_s = 2'(win); end
    end
    @(posedge Clk);
    #1;
    for (int s = 0; s < 4; s++) er[s] = !h_v[s];
    chk("cdb_valid", Cdb_Valid, m_v);
    chk("cdb_data", Cdb_Data, m_d);
    chk("cdb_tag", Cdb_RobTag, m_t);
    chk("cdb_phy", Cdb_PhyAddr, m_p);
    chk("cdb_src", Cdb_Src, m_s);
    chk("ready", rdy, er);
  endtask

  task automatic idle();
    vld = '0; fl = 0;
  endtask

  task automatic put(input int s, input logic [31:0] d, input logic [4:0] t);
    vld[s] = 1; dat[s] = d; tag[s] = t; phy[s] = 6'(s + 8);
  endtask

  task automatic do_reset();
    idle(); Reset = 1; cycle(); Reset = 0;
  endtask

  initial begin
    int n;
    Reset = 1; vld = '0; fl = 0; fd = 0; top = 0;
    for (int s = 0; s < 4; s++) begin dat[s] = 0; tag[s] = 0; phy[s] = 0; end
    cycle(); cycle();
    chk("rst_valid", Cdb_Valid, 0);
    chk("rst_data", Cdb_Data, 0);
    chk("rst_src", Cdb_Src, 0);
    chk("rst_ready", rdy, 4'hF);
    Reset = 0;
    // single source
    put(0, 32'hAA, 5'd3); cycle(); idle();
    chk("single_valid", Cdb_Valid, 1);
    chk("single_data", Cdb_Data, 32'hAA);
    chk("single_src", Cdb_Src, 0);
    chk("single_ready", r0, 1);
    // four-way collision
    for (int s = 0; s < 4; s++) put(s, 32'h100 + s, 5'(s));
    cycle(); idle();
    for (int c = 0; c < 4; c++) begin
      logic [7:0] order, lrdy;
      order = 8'b01_00_10_11;
      lrdy  = 8'b1000;
      if (c > 0) cycle();
      chk("four_src", Cdb_Src, order[2*c +: 2]);
      chk("four_lsb_ready", r1, lrdy[c]);
    end
    // fairness after reset
    do_reset();
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      idle();
      if (r0) put(0, 32'h200 + c, 5'(c));
      if (r1) put(1, 32'h300 + c, 5'(c));
      cycle();
      if (Cdb_Valid) begin chk("rr_src", Cdb_Src, 2'(n % 2)); n++; end
    end
    chk("rr_count", n, 8);
    idle(); cycle(); cycle();
    // flush kills a held Mul entry, live Int survives
    do_reset();
    top = 30;
    put(3, 32'hD0, 5'd5); put(2, 32'h20, 5'd2); cycle(); idle();
    chk("fl_div_src", Cdb_Src, 3);
    chk("fl_mul_held", r2, 0);
    put(0, 32'h11, 5'd31); fl = 1; fd = 2; cycle(); idle();
    chk("fl_int_src", Cdb_Src, 0);
    chk("fl_int_data", Cdb_Data, 32'h11);
    chk("fl_mul_ready", r2, 1);
    cycle();
    chk("fl_no_mul", Cdb_Valid, 0);
    // boundary depth and tag wrap
    top = 31;
    put(0, 32'h33, 5'd1); fl = 1; fd = 2; cycle(); idle();
    chk("bnd_equal", Cdb_Valid, 1);
    chk("bnd_data", Cdb_Data, 32'h33);
    put(0, 32'h44, 5'd0); fl = 1; fd = 1; cycle(); idle();
    chk("wrap_keep", Cdb_Data, 32'h44);
    put(0, 32'h55, 5'd0); fl = 1; fd = 0; cycle(); idle();
    chk("wrap_kill", Cdb_Valid, 0);
    chk("wrap_kill_ready", r0, 1);
    // reset with entries held
    for (int s = 0; s < 4; s++) put(s, 32'h600 + s, 5'(s));
    top = 0; cycle(); idle();
    chk("mid_held", rdy, 4'h8);
    Reset = 1; cycle(); Reset = 0;
    chk("mid_rst_valid", Cdb_Valid, 0);
    chk("mid_rst_ready", rdy, 4'hF);
    cycle(); chk("mid_stale0", Cdb_Valid, 0);
    cycle(); chk("mid_stale1", Cdb_Valid, 0);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      Reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) top = 5'($urandom);
      for (int s = 0; s < 4; s++)
        if (!h_v[s] && $urandom_range(0, 99) < 45) begin
          vld[s] = 1; dat[s] = $urandom; tag[s] = 5'($urandom); phy[s] = 6'($urandom);
        end
      fl = ($urandom_range(0, 7) == 0);
      fd = 5'($urandom);
      cycle();
    end
    Reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
